// File: rtl/rv_pkg.sv
// Shared RV front-end types: datapath width, PCSrc redirect encoding and fetch states.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JALR   = 2'b10
    } pcsrc_e;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
interface fetch_unit_if #(
    parameter int unsigned XLEN = rv_pkg::XLEN
) ();

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small FIFO holding {pc, instr} pairs for decode; flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a slot is only read once count covers it.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credited imem requests,
// queues returned words for decode and handles PCSrc redirects with response dropping.
module fetch_unit #(
    parameter int unsigned     XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    imem,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            instr_ready,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] alu_result,
    output logic            fetch_fault
);
    import rv_pkg::*;

    localparam int unsigned     CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    fetch_state_e    state_q, state_d;
    logic            fault_q, fault_d;
    logic            live_q;

    logic [CW-1:0]   fifo_count;
    logic [XLEN-1:0] head_pc, head_instr;
    logic [CW:0]     inflight_live, inflight_mem;
    logic [XLEN-1:0] target;
    logic            redirect, misaligned, req_valid, accept, push, pop;

    always_comb begin
        redirect = 1'b0;
        target   = pc_target;
        case (PCSrc)
            PCSRC_BRANCH: redirect = 1'b1;
            PCSRC_JALR: begin
                redirect = 1'b1;
                target   = alu_result & ~XLEN'(1);
            end
            default: ;
        endcase
    end

    assign misaligned    = redirect && target[1];
    assign inflight_live = {1'b0, outstanding_q} + {1'b0, fifo_count};
    // Also bound requests still owed by memory, so drop_cnt can never exceed DEPTH.
    assign inflight_mem  = {1'b0, outstanding_q} + {1'b0, drop_cnt_q};
    assign req_valid     = live_q && (state_q == RUN) && !redirect &&
                           (inflight_live < DEPTH_W) && (inflight_mem < DEPTH_W);
    assign accept        = req_valid && imem.imem_req_ready;
    assign push          = imem.imem_rsp_valid && (drop_cnt_q == '0) && !redirect;
    assign pop           = instr_valid && instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        state_d       = state_q;
        fault_d       = 1'b0;
        if (redirect) begin
            fetch_pc_d    = target;
            rsp_pc_d      = target;
            outstanding_d = '0;
            // The response of this cycle, live or stale, is consumed as a drop.
            drop_cnt_d    = drop_cnt_q + outstanding_q + CW'(accept)
                            - CW'(imem.imem_rsp_valid);
            state_d       = misaligned ? FAULT : RUN;
            fault_d       = misaligned;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (imem.imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
            if (push) rsp_pc_d = rsp_pc_q + XLEN'(4);
            outstanding_d = outstanding_q + CW'(accept) - CW'(push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            state_q       <= RUN;
            fault_q       <= 1'b0;
            live_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            state_q       <= state_d;
            fault_q       <= fault_d;
            live_q        <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fetch_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i ({rsp_pc_q, imem.imem_rsp_data}),
        .pop_i   (pop),
        .flush_i (redirect),
        .rdata_o ({head_pc, head_instr}),
        .count_o (fifo_count)
    );

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;
    assign instr_valid         = (fifo_count != '0);
    assign instr               = head_instr;
    assign instr_pc            = head_pc;
    assign instr_pc_plus4      = head_pc + XLEN'(4);
    assign fetch_fault         = fault_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that consumes the control unit's PCSrc redirect encoding.
- Owns the architectural fetch PC and issues in-order requests to instruction memory over a valid/ready request channel.
- Buffers returned instruction words in a small queue and hands them to decode with a valid/ready handshake.
- On a redirect (branch taken, JAL, JALR), flushes the queue, discards in-flight responses and refetches from the new target.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction queue entries; this is also the maximum number of outstanding requests (power of two, ≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address; word aligned.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response word valid; responses return in order, one per accepted request, at least 1 cycle later.
- imem_rsp_data  in  XLEN  instruction word.
- instr_valid  out  1  queue head valid to decode.
- instr  out  XLEN  queue head instruction.
- instr_pc  out  XLEN  PC of the queue head.
- instr_pc_plus4  out  XLEN  instr_pc+4.
- instr_ready  in  1  decode consumes the head.
- PCSrc  in  2  redirect select: 00 = sequential, 01 = PC+imm, 10 = JALR.
- pc_target  in  XLEN  PC+imm from execute.
- alu_result  in  XLEN  rs1+imm from execute.
- fetch_fault  out  1  one-cycle pulse on a misaligned redirect target.

Behaviour:
- Reset values: fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; imem_req_valid=0; instr_valid=0; fetch_fault=0; state=RUN. Pointers and counters are the only reset registers; queue data is not reset.
- Credit rule: imem_req_valid=1 only when all of the following hold:
  - state==RUN;
  - no redirect this cycle;
  - outstanding + occupancy < DEPTH, where outstanding counts live (non-dropped) requests.
- imem_req_addr=fetch_pc. On accept (valid&ready): fetch_pc += 4 (wraps mod 2^XLEN); outstanding++.
- Response handling:
  - If drop_cnt>0: the response is discarded and drop_cnt--.
  - Otherwise it is written to the queue tail with its PC (tracked in a PC-of-next-response register), and outstanding--.
- Queue: FIFO, registered outputs. Write and read in the same cycle are legal when full, because the credit rule guarantees no overflow. instr_valid = occupancy ≠ 0. The first word reaches decode at the earliest 1 cycle after imem_rsp_valid.
- Redirect: active when PCSrc≠00. Target is pc_target (01) or {alu_result[XLEN-1:1],1'b0} (10). PCSrc=11 is treated as 00. On a redirect, the next edge applies all of the following:
  - queue flushed (occupancy=0);
  - drop_cnt += outstanding, including any request accepted in the same cycle;
  - outstanding=0;
  - fetch_pc=target.
  A response arriving in the redirect cycle is counted against the drop and is not enqueued. A decode handshake in the redirect cycle completes, then the queue is flushed.
- Misaligned target (target[1]=1): fetch_fault pulses for 1 cycle, state goes to FAULT, and no requests are issued. drop_cnt still drains. FAULT exits to RUN only on a new aligned redirect.
- States: RUN → FAULT on a misaligned redirect. FAULT → RUN on an aligned redirect. No other transitions.
- Asynchronous reset mid-operation returns to reset values immediately. Memory responses after reset are the integrator's responsibility: the memory is reset together with this block.
- Counter width is $clog2(DEPTH)+1; drop_cnt never exceeds DEPTH.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN;
  - pcsrc_e enum (PCSRC_PLUS4=2'b00, PCSRC_BRANCH=2'b01, PCSRC_JALR=2'b10), also used by the control unit;
  - fetch_state_e (RUN, FAULT).
- Sub-module fetch_fifo (parameters DEPTH, WIDTH=2*XLEN): stores {pc, instr}, has push/pop/flush, and outputs count.

Test Plan:
- Reset release, memory latency 1, instr_ready=1 → requests 0x0,0x4,0x8,...; the word for 0x0 appears with instr_pc=0x0 and instr_pc_plus4=0x4.
- instr_ready=0 for 10 cycles → at most DEPTH=2 requests issued; no queue overflow; stored words delivered in order once ready rises.
- 2 requests in flight, then PCSrc=01 with pc_target=0x100 → both stale responses dropped, next request addr=0x100, first delivered instr_pc=0x100.
- PCSrc=10 with alu_result=0x205 → fetch resumes at 0x204 with no fault.
- PCSrc=01 with pc_target=0x102 → fetch_fault pulses once, no requests follow; then PCSrc=01 with pc_target=0x40 → fetching resumes at 0x40.
- rst_n deasserted mid-burst with a response pending → outputs return to reset values immediately; the first request after release is RESET_PC.
